// File: rtl/frame_buffer_manager.sv
// Rotates SDRAM frame banks between the camera writer and the display reader.
// Writer, latest-complete and reader banks stay distinct; drops and repeats are counted.
module frame_buffer_manager #(
  parameter int unsigned NUM_BANKS   = 3,
  parameter int unsigned FRAME_WORDS = 130560,
  parameter int unsigned ADDR_W      = 22
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sdram_init_done,
  input  logic              bank_valid,
  input  logic              frame_write_done,
  input  logic              frame_read_done,
  input  logic              freeze,
  output logic [1:0]        wr_bank,
  output logic [1:0]        rd_bank,
  output logic              wr_load,
  output logic              rd_load,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] wr_max_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] rd_max_addr,
  output logic [15:0]       frames_dropped,
  output logic [15:0]       frames_repeated
);

  localparam int unsigned OFF_W = ADDR_W - 2;
  localparam logic [OFF_W-1:0] MAX_OFF = OFF_W'(FRAME_WORDS);

  typedef enum logic [1:0] {W_INIT, W_WAIT, W_WRITE, W_BLOCK} wstate_t;

  wstate_t r_state, w_state_nx;

  logic [1:0]        r_wr_bank, r_rd_bank, r_latest;
  logic              r_latest_valid, r_wr_load, r_rd_load;
  logic              r_bv_d, r_init_d;
  logic [15:0]       r_dropped, r_repeated;
  logic [ADDR_W-1:0] r_wr_addr, r_wr_max, r_rd_addr, r_rd_max;

  logic       w_bv_rise, w_init_rise, w_commit, w_rd_ev, w_take;
  logic [1:0] w_lat_c, w_rd_nx, w_wr_nx, w_free;
  logic       w_lv_c, w_lv_nx, w_free_ok, w_wr_load_nx, w_drop;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic inc);
    return (inc && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

  // A commit in this cycle is visible to the reader before it decides what to take.
  always_comb begin
    w_bv_rise   = bank_valid & ~r_bv_d;
    w_init_rise = sdram_init_done & ~r_init_d;
    w_commit    = (r_state == W_WRITE) & frame_write_done;
    w_rd_ev     = frame_read_done & sdram_init_done;
    w_lat_c     = w_commit ? r_wr_bank : r_latest;
    w_lv_c      = w_commit | r_latest_valid;
    w_take      = w_rd_ev & w_lv_c & ~freeze;
    w_rd_nx     = w_take ? w_lat_c : r_rd_bank;
    w_lv_nx     = w_lv_c & ~w_take;
  end

  always_comb begin
    w_free    = '0;
    w_free_ok = 1'b0;
    for (int unsigned i = 0; i < NUM_BANKS; i++) begin
      if (!w_free_ok && 2'(i) != w_rd_nx && !(w_lv_nx && 2'(i) == w_lat_c)) begin
        w_free    = 2'(i);
        w_free_ok = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_wr_nx      = r_wr_bank;
    w_wr_load_nx = 1'b0;
    w_drop       = 1'b0;
    case (r_state)
      W_INIT: if (sdram_init_done) w_state_nx = W_WAIT;
      W_WAIT: if (w_bv_rise) begin
        w_state_nx   = W_WRITE;
        w_wr_load_nx = 1'b1;
      end
      W_WRITE: begin
        if (w_commit) begin
          w_drop = r_latest_valid;
          if (w_free_ok) begin
            w_wr_nx      = w_free;
            w_state_nx   = w_bv_rise ? W_WRITE : W_WAIT;
            w_wr_load_nx = w_bv_rise;
          end else begin
            w_state_nx = W_BLOCK;
          end
        end else if (w_bv_rise) begin
          w_wr_load_nx = 1'b1;
        end
      end
      W_BLOCK: begin
        w_drop = w_bv_rise;
        if (w_free_ok) begin
          w_wr_nx    = w_free;
          w_state_nx = W_WAIT;
        end
      end
      default: w_state_nx = W_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= W_INIT;
      r_rd_bank      <= 2'd0;
      r_wr_bank      <= 2'd1;
      r_latest       <= 2'd0;
      r_latest_valid <= 1'b0;
      r_wr_load      <= 1'b0;
      r_rd_load      <= 1'b0;
      r_bv_d         <= 1'b0;
      r_init_d       <= 1'b0;
      r_dropped      <= '0;
      r_repeated     <= '0;
      r_wr_addr      <= {2'd1, {OFF_W{1'b0}}};
      r_wr_max       <= {2'd1, MAX_OFF};
      r_rd_addr      <= {2'd0, {OFF_W{1'b0}}};
      r_rd_max       <= {2'd0, MAX_OFF};
    end else begin
      r_state        <= w_state_nx;
      r_rd_bank      <= w_rd_nx;
      r_wr_bank      <= w_wr_nx;
      r_latest       <= w_lat_c;
      r_latest_valid <= w_lv_nx;
      r_wr_load      <= w_wr_load_nx;
      r_rd_load      <= w_init_rise | w_rd_ev;
      r_bv_d         <= bank_valid;
      r_init_d       <= sdram_init_done;
      r_dropped      <= sat_inc(r_dropped, w_drop);
      r_repeated     <= sat_inc(r_repeated, w_rd_ev & ~w_take);
      r_wr_addr      <= {w_wr_nx, {OFF_W{1'b0}}};
      r_wr_max       <= {w_wr_nx, MAX_OFF};
      r_rd_addr      <= {w_rd_nx, {OFF_W{1'b0}}};
      r_rd_max       <= {w_rd_nx, MAX_OFF};
    end
  end

  assign wr_bank         = r_wr_bank;
  assign rd_bank         = r_rd_bank;
  assign wr_load         = r_wr_load;
  assign rd_load         = r_rd_load;
  assign wr_addr         = r_wr_addr;
  assign wr_max_addr     = r_wr_max;
  assign rd_addr         = r_rd_addr;
  assign rd_max_addr     = r_rd_max;
  assign frames_dropped  = r_dropped;
  assign frames_repeated = r_repeated;

endmodule

// File: tb/tb_frame_buffer_manager.sv
// Scoreboard bench for frame_buffer_manager: a 3-bank and a 2-bank instance share stimulus,
// expected load-pulse contents are queued when stimulus is driven and checked when pulses appear.
module tb_frame_buffer_manager;

  typedef struct packed {
    logic [1:0]  bank;
    logic [21:0] addr;
    logic [21:0] max;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, init_done, bv, fwd, frd, frz;

  logic [1:0]  wb3, rb3, wb2, rb2;
  logic        wl3, rl3, wl2, rl2;
  logic [21:0] wa3, wm3, ra3, rm3, wa2, wm2, ra2, rm2;
  logic [15:0] dr3, rp3, dr2, rp2;

  frame_buffer_manager #(.NUM_BANKS(3), .FRAME_WORDS(130560), .ADDR_W(22)) dut3 (
    .clk(clk), .rst_n(rst_n), .sdram_init_done(init_done), .bank_valid(bv),
    .frame_write_done(fwd), .frame_read_done(frd), .freeze(frz),
    .wr_bank(wb3), .rd_bank(rb3), .wr_load(wl3), .rd_load(rl3),
    .wr_addr(wa3), .wr_max_addr(wm3), .rd_addr(ra3), .rd_max_addr(rm3),
    .frames_dropped(dr3), .frames_repeated(rp3));

  frame_buffer_manager #(.NUM_BANKS(2), .FRAME_WORDS(130560), .ADDR_W(22)) dut2 (
    .clk(clk), .rst_n(rst_n), .sdram_init_done(init_done), .bank_valid(bv),
    .frame_write_done(fwd), .frame_read_done(frd), .freeze(frz),
    .wr_bank(wb2), .rd_bank(rb2), .wr_load(wl2), .rd_load(rl2),
    .wr_addr(wa2), .wr_max_addr(wm2), .rd_addr(ra2), .rd_max_addr(rm2),
    .frames_dropped(dr2), .frames_repeated(rp2));

  bit sel = 1'b0;
  logic [1:0]  m_wb, m_rb;
  logic        m_wl, m_rl;
  logic [21:0] m_wa, m_wm, m_ra, m_rm;
  logic [15:0] m_dr, m_rp;

  always_comb begin
    m_wb = sel ? wb2 : wb3;  m_rb = sel ? rb2 : rb3;
    m_wl = sel ? wl2 : wl3;  m_rl = sel ? rl2 : rl3;
    m_wa = sel ? wa2 : wa3;  m_wm = sel ? wm2 : wm3;
    m_ra = sel ? ra2 : ra3;  m_rm = sel ? rm2 : rm3;
    m_dr = sel ? dr2 : dr3;  m_rp = sel ? rp2 : rp3;
  end

  int n_checks = 0;
  int n_errors = 0;
  exp_t wr_q[$];
  exp_t rd_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t ex(input logic [1:0] b);
    exp_t e;
    e.bank = b;
    e.addr = {b, 20'd0};
    e.max  = {b, 20'd130560};
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (m_wl) begin
      if (wr_q.size() == 0) check("wr_load_extra", 32'd1, 32'd0);
      else begin
        e = wr_q.pop_front();
        check("wr_bank@load", 32'(m_wb), 32'(e.bank));
        check("wr_addr@load", 32'(m_wa), 32'(e.addr));
        check("wr_max@load", 32'(m_wm), 32'(e.max));
      end
    end
    if (m_rl) begin
      if (rd_q.size() == 0) check("rd_load_extra", 32'd1, 32'd0);
      else begin
        e = rd_q.pop_front();
        check("rd_bank@load", 32'(m_rb), 32'(e.bank));
        check("rd_addr@load", 32'(m_ra), 32'(e.addr));
        check("rd_max@load", 32'(m_rm), 32'(e.max));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_wr_bank"}, 32'(m_wb), 32'd1);
    check({tag, "_rd_bank"}, 32'(m_rb), 32'd0);
    check({tag, "_wr_load"}, 32'(m_wl), 32'd0);
    check({tag, "_rd_load"}, 32'(m_rl), 32'd0);
    check({tag, "_wr_addr"}, 32'(m_wa), 32'h100000);
    check({tag, "_wr_max"}, 32'(m_wm), 32'h11FE00);
    check({tag, "_rd_addr"}, 32'(m_ra), 32'h000000);
    check({tag, "_rd_max"}, 32'(m_rm), 32'h01FE00);
    check({tag, "_dropped"}, 32'(m_dr), 32'd0);
    check({tag, "_repeated"}, 32'(m_rp), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; init_done = 1'b0; bv = 1'b0; fwd = 1'b0; frd = 1'b0; frz = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic do_init(input logic [1:0] rb);
    rd_q.push_back(ex(rb));
    init_done = 1'b1;
    tick(2);
  endtask

  task automatic do_frame(input logic [1:0] wb);
    wr_q.push_back(ex(wb));
    bv = 1'b1;
    tick(3);
    fwd = 1'b1;
    tick(1);
    fwd = 1'b0; bv = 1'b0;
    tick(2);
  endtask

  task automatic do_read(input logic [1:0] rb);
    rd_q.push_back(ex(rb));
    frd = 1'b1;
    tick(1);
    frd = 1'b0;
    tick(1);
  endtask

  task automatic drain(input string tag);
    tick(3);
    check({tag, "_wr_q_empty"}, 32'(wr_q.size()), 32'd0);
    check({tag, "_rd_q_empty"}, 32'(rd_q.size()), 32'd0);
  endtask

  initial begin
    // reset values, and events before init must be ignored
    sel = 1'b0;
    do_reset();
    check_reset_vals("rst");
    frd = 1'b1; fwd = 1'b1;
    tick(1);
    frd = 1'b0; fwd = 1'b0;
    tick(2);
    check("pre_init_repeated", 32'(m_rp), 32'd0);
    check("pre_init_rd_bank", 32'(m_rb), 32'd0);
    drain("pre_init");

    // three frames written with no reads
    do_init(2'd0);
    do_frame(2'd1);
    do_frame(2'd2);
    do_frame(2'd1);
    check("seq_wr_bank", 32'(m_wb), 32'd2);
    check("seq_dropped", 32'(m_dr), 32'd2);
    check("seq_rd_bank", 32'(m_rb), 32'd0);
    do_read(2'd1);
    check("seq_rd_after", 32'(m_rb), 32'd1);
    drain("seq");

    // write done then read done
    do_reset();
    do_init(2'd0);
    do_frame(2'd1);
    do_read(2'd1);
    check("wr_rd_rd_bank", 32'(m_rb), 32'd1);
    check("wr_rd_rd_addr", 32'(m_ra), 32'h100000);
    check("wr_rd_rd_max", 32'(m_rm), 32'h11FE00);
    check("wr_rd_wr_bank", 32'(m_wb), 32'd2);
    drain("wr_rd");

    // simultaneous write done and read done
    do_reset();
    do_init(2'd0);
    wr_q.push_back(ex(2'd1));
    bv = 1'b1;
    tick(3);
    rd_q.push_back(ex(2'd1));
    fwd = 1'b1; frd = 1'b1;
    tick(1);
    fwd = 1'b0; frd = 1'b0; bv = 1'b0;
    tick(2);
    check("sim_rd_bank", 32'(m_rb), 32'd1);
    check("sim_wr_bank", 32'(m_wb), 32'd0);
    check("sim_wr_addr", 32'(m_wa), 32'h000000);
    do_read(2'd1);
    check("sim_repeated", 32'(m_rp), 32'd1);
    check("sim_dropped", 32'(m_dr), 32'd0);
    drain("sim");

    // freeze holds the display but not the writer
    do_reset();
    do_init(2'd0);
    do_frame(2'd1);
    frz = 1'b1;
    for (int i = 0; i < 4; i++) do_read(2'd0);
    check("frz_rd_bank", 32'(m_rb), 32'd0);
    check("frz_repeated", 32'(m_rp), 32'd4);
    do_frame(2'd2);
    check("frz_dropped", 32'(m_dr), 32'd1);
    check("frz_wr_bank", 32'(m_wb), 32'd1);
    frz = 1'b0;
    do_read(2'd2);
    check("unfrz_rd_bank", 32'(m_rb), 32'd2);
    check("unfrz_repeated", 32'(m_rp), 32'd4);
    drain("frz");

    // re-rise aborts the frame on the same bank, then reset lands mid-frame
    do_reset();
    do_init(2'd0);
    wr_q.push_back(ex(2'd1));
    bv = 1'b1;
    tick(2);
    bv = 1'b0;
    tick(1);
    wr_q.push_back(ex(2'd1));
    bv = 1'b1;
    tick(2);
    rst_n = 1'b0; fwd = 1'b1;
    tick(1);
    fwd = 1'b0; bv = 1'b0;
    tick(1);
    check_reset_vals("midrst");
    rd_q.push_back(ex(2'd0));
    rst_n = 1'b1;
    tick(2);
    do_frame(2'd1);
    check("midrst_dropped", 32'(m_dr), 32'd0);
    do_read(2'd1);
    check("midrst_rd_bank", 32'(m_rb), 32'd1);
    drain("midrst");

    // two-bank instance blocks the writer until the reader consumes
    sel = 1'b1;
    do_reset();
    check_reset_vals("nb2_rst");
    do_init(2'd0);
    do_frame(2'd1);
    bv = 1'b1;
    tick(3);
    fwd = 1'b1;
    tick(1);
    fwd = 1'b0; bv = 1'b0;
    tick(2);
    check("nb2_block_dropped", 32'(m_dr), 32'd1);
    do_read(2'd1);
    check("nb2_rd_bank", 32'(m_rb), 32'd1);
    check("nb2_wr_bank", 32'(m_wb), 32'd0);
    do_frame(2'd0);
    check("nb2_dropped_after", 32'(m_dr), 32'd1);
    drain("nb2");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
